// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, access legality.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_READ,
        ST_STORE,
        ST_RESP
    } lsu_state_e;

    // True when the request must be rejected: unknown funct3 for its direction, or misaligned.
    function automatic logic lsu_bad_access(input logic we, input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = lo[0];
            F3_W:    bad = (lo != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, lane merge into the old word for stores.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = mem_rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    // Right-align the addressed lane and extend it to 32 bits.
    always_comb begin
        load_data = mem_rdata;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h000000, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0000, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    // Replace only the addressed byte/half of the previously read word; SW takes wdata whole.
    always_comb begin
        store_word = wdata;
        case (funct3)
            F3_B: begin
                store_word = old_word;
                store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            F3_H: begin
                store_word = old_word;
                if (addr_lo[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time to a word-wide memory, sub-word stores via read-modify-write.
// Latency: error 1 cycle, load/SW 2 cycles, SB/SH 3 cycles from accept to the resp_valid pulse.
// Backpressure: req_ready is high only in IDLE; a request held while busy waits untouched.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    // Holds the extended load result, or the old word read for a sub-word store.
    logic [31:0]       data_q, data_d;

    logic              acc_err;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    assign acc_err = lsu_bad_access(req_we, req_funct3, req_addr[1:0]);

    lsu_align u_align (
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .mem_rdata  (mem_rdata),
        .wdata      (wdata_q),
        .old_word   (data_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // State and captured request registers; reset also aborts any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            err_q    <= 1'b0;
            data_q   <= 32'h0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            data_q   <= data_d;
        end
    end

    // Next state, request capture and memory strobes.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        data_d    = data_q;
        req_ready = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = acc_err;
                    data_d   = 32'h0;
                    if (acc_err) begin
                        state_d = ST_RESP;
                    end else if (!req_we) begin
                        state_d = ST_LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_d = ST_STORE;
                    end else begin
                        state_d = ST_RMW_READ;
                    end
                end
            end
            ST_LOAD: begin
                mem_read = 1'b1;
                data_d   = load_data;
                state_d  = ST_RESP;
            end
            ST_RMW_READ: begin
                mem_read = 1'b1;
                data_d   = mem_rdata;
                state_d  = ST_STORE;
            end
            ST_STORE: begin
                mem_write = 1'b1;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = (resp_valid && !we_q && !err_q) ? data_q : 32'h0;
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata  = (state_q == ST_STORE) ? store_word : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed requests against a small word memory and a behavioural model.
// Latency: the model predicts the exact cycle of every response.
// Backpressure: exercised by holding req_valid high across a busy transaction.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Word memory: combinational read, write on the clock edge.
    logic [31:0] tb_mem [16] = '{32'h0, 32'h0, 32'h80FF7F01, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    assign mem_rdata = tb_mem[mem_addr[5:2]];
    always @(posedge clk) if (mem_write) tb_mem[mem_addr[5:2]] <= mem_wdata;

    int cyc = 0;
    int n_rd = 0;
    int n_wr = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (mem_read)  n_rd <= n_rd + 1;
        if (mem_write) n_wr <= n_wr + 1;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outcome of one pending request.
    bit          chk_on = 1'b0;
    bit          pend = 1'b0;
    int          acc_c = 0;
    int          resp_cyc = 0;
    int          exp_rd = 0;
    int          exp_wr = 0;
    int          rd0 = 0;
    int          wr0 = 0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic [31:0] exp_word = 32'h0;
    logic [31:0] exp_maddr = 32'h0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err = 1'b0;

    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] word,
                                  output logic err, output logic [31:0] rdata,
                                  output logic [31:0] newword, output int lat,
                                  output int rd, output int wr);
        int          sh;
        int          nb;
        logic        legal;
        logic [31:0] mask;
        sh    = int'(addr[1:0]) * 8;
        nb    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mask  = (nb == 1) ? 32'hFF : (nb == 2) ? 32'hFFFF : 32'hFFFFFFFF;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err   = !legal || ((int'(addr[1:0]) % nb) != 0);
        rdata = 32'h0;
        newword = word;
        rd = 0;
        wr = 0;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            rd = 1;
            rdata = (word >> sh) & mask;
            if (!f3[2] && nb < 4 && rdata[nb*8-1]) rdata = rdata | ~mask;
        end else begin
            wr = 1;
            rd = (nb < 4) ? 1 : 0;
            lat = (nb < 4) ? 3 : 2;
            newword = (word & ~(mask << sh)) | ((wdata << sh) & (mask << sh));
        end
    endfunction

    // Per-cycle comparison of DUT outputs against the pending expectation.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("req_ready", {31'b0, req_ready}, {31'b0, !(pend && cyc > acc_c)});
            chk("rd_wr_overlap", {31'b0, mem_read & mem_write}, 32'h0);
            if (pend && cyc > acc_c) chk("mem_addr", mem_addr, exp_maddr);
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, pend && cyc == resp_cyc});
            if (pend && cyc == resp_cyc) begin
                chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("mem_reads", n_rd - rd0, exp_rd);
                chk("mem_writes", n_wr - wr0, exp_wr);
                chk("mem_word", tb_mem[exp_maddr[5:2]], exp_word);
                chk("strobes_in_resp", {30'b0, mem_read, mem_write}, 32'h0);
                last_rdata = resp_rdata;
                last_err = resp_err;
                pend = 1'b0;
            end
        end
    end

    // Present a request, wait for acceptance, record the model's prediction; returns at the accept edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        int lat;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        for (int i = 0; i < 30 && !req_ready; i++) @(negedge clk);
        chk("accept", {31'b0, req_ready}, 32'h1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        model(we, f3, addr, wdata, tb_mem[addr[5:2]], exp_err, exp_rdata, exp_word, lat, exp_rd, exp_wr);
        exp_maddr = {addr[31:2], 2'b00};
        rd0 = n_rd;
        wr0 = n_wr;
        acc_c = cyc;
        resp_cyc = cyc + lat;
        pend = 1'b1;
        @(posedge clk);
    endtask

    task automatic finish_req();
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 10 && pend; i++) @(negedge clk);
        chk("resp_timeout", {31'b0, pend}, 32'h0);
        pend = 1'b0;
    endtask

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] lit;
        logic        lit_err;
    } vec_t;

    // lit: hand-computed load result (or word in memory after a store).
    vec_t vecs [16] = '{
        '{1'b0, 3'd0, 32'hB, 32'h0,    32'hFFFFFF80, 1'b0},
        '{1'b0, 3'd4, 32'hB, 32'h0,    32'h00000080, 1'b0},
        '{1'b0, 3'd1, 32'hA, 32'h0,    32'hFFFF80FF, 1'b0},
        '{1'b0, 3'd5, 32'hA, 32'h0,    32'h000080FF, 1'b0},
        '{1'b0, 3'd2, 32'h8, 32'h0,    32'h80FF7F01, 1'b0},
        '{1'b0, 3'd0, 32'h8, 32'h0,    32'h00000001, 1'b0},
        '{1'b0, 3'd0, 32'h9, 32'h0,    32'h0000007F, 1'b0},
        '{1'b0, 3'd2, 32'h6, 32'h0,    32'h00000000, 1'b1},
        '{1'b1, 3'd1, 32'h5, 32'h1234, 32'h00000000, 1'b1},
        '{1'b0, 3'd3, 32'h8, 32'h0,    32'h00000000, 1'b1},
        '{1'b1, 3'd4, 32'h8, 32'h55,   32'h00000000, 1'b1},
        '{1'b1, 3'd0, 32'h9, 32'hAA,   32'h80FFAA01, 1'b0},
        '{1'b1, 3'd1, 32'h8, 32'h1234, 32'h80FF1234, 1'b0},
        '{1'b1, 3'd1, 32'hA, 32'hBEEF, 32'hBEEF1234, 1'b0},
        '{1'b1, 3'd0, 32'hB, 32'h5A,   32'h5AEF1234, 1'b0},
        '{1'b0, 3'd1, 32'hA, 32'h0,    32'h00005AEF, 1'b0}
    };

    initial begin
        logic [31:0] orig;
        @(negedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        rst = 1'b0;
        chk_on = 1'b1;

        for (int v = 0; v < 16; v++) begin
            issue(vecs[v].we, vecs[v].f3, vecs[v].addr, vecs[v].wdata);
            finish_req();
            chk($sformatf("vec%0d_err", v), {31'b0, last_err}, {31'b0, vecs[v].lit_err});
            if (vecs[v].we && !vecs[v].lit_err)
                chk($sformatf("vec%0d_word", v), tb_mem[vecs[v].addr[5:2]], vecs[v].lit);
            else
                chk($sformatf("vec%0d_rdata", v), last_rdata, vecs[v].lit);
        end

        // Reset during the read half of a sub-word store aborts it without a write.
        orig = tb_mem[2];
        issue(1'b1, 3'd0, 32'h9, 32'h33);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_in_rmw_read", {31'b0, mem_read}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1 pend = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", {31'b0, req_ready}, 32'h1);
        chk("abort_no_resp", {31'b0, resp_valid}, 32'h0);
        chk("abort_no_write", {31'b0, mem_write}, 32'h0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        chk("abort_mem_word", tb_mem[2], orig);
        chk("abort_write_count", n_wr - wr0, 32'h0);

        // SW then LW with req_valid held high throughout the store.
        issue(1'b1, 3'd2, 32'h10, 32'hCAFEF00D);
        issue(1'b0, 3'd2, 32'h10, 32'h0);
        finish_req();
        chk("b2b_word", tb_mem[4], 32'hCAFEF00D);
        chk("b2b_lw", last_rdata, 32'hCAFEF00D);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
